// File: rtl/alu_op_server.sv
// alu_op_server: sequential responder for ALU operation requests.
//
// Accepts one {op, X, Y} request over a valid/ready handshake, computes it
// (shifts run one bit per cycle), then returns {Z, equal, overflow, zero}
// over a second valid/ready handshake. Only one request is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rstb       synchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request (IDLE)
//   req_op     op code (ALU_OP_*)
//   req_x      operand X (signed)
//   req_y      operand Y (signed); Y[SHAMT_W-1:0] is the shift amount
//   rsp_valid  response present (RESP)
//   rsp_ready  consumer takes the response
//   rsp_z      result Z
//   rsp_equal  X == Y
//   rsp_ovf    signed overflow (ADD/SUB only)
//   rsp_zero   Z == 0
module alu_op_server #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_equal,
    output logic             rsp_ovf,
    output logic             rsp_zero
);

    // ALU op encodings
    localparam logic [3:0] ALU_OP_AND = 4'd0;
    localparam logic [3:0] ALU_OP_OR  = 4'd1;
    localparam logic [3:0] ALU_OP_XOR = 4'd2;
    localparam logic [3:0] ALU_OP_NOR = 4'd3;
    localparam logic [3:0] ALU_OP_ADD = 4'd4;
    localparam logic [3:0] ALU_OP_SUB = 4'd5;
    localparam logic [3:0] ALU_OP_SLT = 4'd6;
    localparam logic [3:0] ALU_OP_SRL = 4'd7;
    localparam logic [3:0] ALU_OP_SLL = 4'd8;
    localparam logic [3:0] ALU_OP_SRA = 4'd9;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               equal_q, equal_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               is_shift;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res;
    logic               res_ovf;
    logic               res_valid_op;

    assign is_shift = (op_q == ALU_OP_SRL) || (op_q == ALU_OP_SLL) || (op_q == ALU_OP_SRA);
    assign sum      = x_q + y_q;
    assign diff     = x_q - y_q;

    // Final result for the captured op; shifts read the finished working reg.
    always_comb begin
        res          = '0;
        res_ovf      = 1'b0;
        res_valid_op = 1'b1;
        case (op_q)
            ALU_OP_AND: res = x_q & y_q;
            ALU_OP_OR:  res = x_q | y_q;
            ALU_OP_XOR: res = x_q ^ y_q;
            ALU_OP_NOR: res = ~(x_q | y_q);
            ALU_OP_ADD: begin
                res     = sum;
                res_ovf = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum[WIDTH-1] != x_q[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                res     = diff;
                res_ovf = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (diff[WIDTH-1] != x_q[WIDTH-1]);
            end
            ALU_OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(x_q) < $signed(y_q))};
            ALU_OP_SRL, ALU_OP_SLL, ALU_OP_SRA: res = work_q;
            default:    res_valid_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        equal_d   = equal_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    x_d     = req_x;
                    y_d     = req_y;
                    work_d  = req_x;
                    cnt_d   = req_y[SHAMT_W-1:0];
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_shift && (cnt_q != '0)) begin
                    case (op_q)
                        ALU_OP_SLL: work_d = {work_q[WIDTH-2:0], 1'b0};
                        ALU_OP_SRA: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                        default:    work_d = {1'b0, work_q[WIDTH-1:1]};
                    endcase
                    cnt_d = cnt_q - SHAMT_W'(1);
                end else begin
                    // Undefined ops report all-zero result and flags.
                    z_d     = res;
                    equal_d = res_valid_op && (x_q == y_q);
                    ovf_d   = res_valid_op && res_ovf;
                    zero_d  = res_valid_op && (res == '0);
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= StIdle;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            equal_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            equal_q <= equal_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign rsp_z     = z_q;
    assign rsp_equal = equal_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_zero  = zero_q;

endmodule
